dual_grant_arbiter: RTL

DUAL_GRANT_ARBITER -- requirements
Module: dual_grant_arbiter

---
 rtl/dual_grant_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dual_grant_arbiter.sv
// -----------------------------------------------------------------------------
// dual_grant_arbiter
//
// Hands two identical resource channels (A and B) to twelve requesters using a
// shared round-robin pointer. Each channel is a two-state FSM (IDLE/BUSY) that
// latches the index of its holder until that channel's done input arrives.
//
// Ports
//   clk_i      : clock, all state updates on the rising edge
//   rst_i      : synchronous active-high reset
//   req_i      : request vector, bit k = requester k+1
//   done_a_i   : channel A holder finished (ignored while A is idle)
//   done_b_i   : channel B holder finished (ignored while B is idle)
//   valid_a_o  : channel A busy
//   grant_a_o  : channel A holder index 1..12, 0 when idle
//   valid_b_o  : channel B busy
//   grant_b_o  : channel B holder index 1..12, 0 when idle
//   rr_ptr_o   : bit position where the next search starts, 0..11
// -----------------------------------------------------------------------------
module dual_grant_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] req_i,
    input  logic        done_a_i,
    input  logic        done_b_i,
    output logic        valid_a_o,
    output logic [3:0]  grant_a_o,
    output logic        valid_b_o,
    output logic [3:0]  grant_b_o,
    output logic [3:0]  rr_ptr_o
);

    localparam int N = 12;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0] state_a_q, state_a_d;
    logic [0:0] state_b_q, state_b_d;
    logic [3:0] grant_a_q, grant_a_d;
    logic [3:0] grant_b_q, grant_b_d;
    logic [3:0] rr_ptr_q,  rr_ptr_d;

    logic        a_idle, b_idle;
    logic [11:0] held_mask;
    logic [11:0] elig;
    logic [11:0] elig_rot;
    logic [3:0]  pos_w [N];

    logic        first_found, second_found;
    logic [3:0]  first_pos, second_pos;
    logic        give_a, give_b;
    logic [3:0]  b_pos;

    assign a_idle = (state_a_q == ST_IDLE);
    assign b_idle = (state_b_q == ST_IDLE);

    // Current holders stay ineligible for the other channel, including on the
    // edge where they are being released.
    // pos_w[gi] is the bit visited gi-th in search order (rr_ptr upward, wrapping
    // at 12); elig_rot reorders the eligible mask into that order.
    for (genvar gi = 0; gi < N; gi++) begin : g_bits
        logic [4:0] sum_w;
        assign held_mask[gi] = (!a_idle && grant_a_q == 4'(gi + 1)) ||
                               (!b_idle && grant_b_q == 4'(gi + 1));
        assign sum_w      = {1'b0, rr_ptr_q} + 5'(gi);
        assign pos_w[gi]  = (sum_w >= 5'd12) ? 4'(sum_w - 5'd12) : sum_w[3:0];
        assign elig_rot[gi] = elig[pos_w[gi]];
    end

    assign elig = req_i & ~held_mask;

    // First and second eligible requesters in search order.
    always_comb begin
        first_found  = 1'b0;
        second_found = 1'b0;
        first_pos    = 4'd0;
        second_pos   = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (elig_rot[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_pos   = pos_w[i];
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_pos   = pos_w[i];
                end
            end
        end
    end

    function automatic logic [3:0] inc_wrap(input logic [3:0] p);
        return (p == 4'd11) ? 4'd0 : p + 4'd1;
    endfunction

    // A channel that is releasing still counts as busy, so it can neither be
    // re-granted nor push the other channel into the "both idle" case.
    always_comb begin
        give_a = 1'b0;
        give_b = 1'b0;
        if (a_idle && b_idle) begin
            give_a = first_found;
            give_b = second_found;
        end else if (a_idle) begin
            give_a = first_found;
        end else if (b_idle) begin
            give_b = first_found;
        end
    end

    // B takes the second pick only when both channels started idle.
    assign b_pos = a_idle ? second_pos : first_pos;

    always_comb begin
        state_a_d = state_a_q;
        grant_a_d = grant_a_q;
        state_b_d = state_b_q;
        grant_b_d = grant_b_q;
        rr_ptr_d  = rr_ptr_q;

        if (!a_idle && done_a_i) begin
            state_a_d = ST_IDLE;
            grant_a_d = 4'd0;
        end else if (give_a) begin
            state_a_d = ST_BUSY;
            grant_a_d = first_pos + 4'd1;
        end

        if (!b_idle && done_b_i) begin
            state_b_d = ST_IDLE;
            grant_b_d = 4'd0;
        end else if (give_b) begin
            state_b_d = ST_BUSY;
            grant_b_d = b_pos + 4'd1;
        end

        // Pointer moves just past the last grant of this edge (B's if both).
        if (give_b) begin
            rr_ptr_d = inc_wrap(b_pos);
        end else if (give_a) begin
            rr_ptr_d = inc_wrap(first_pos);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_a_q <= ST_IDLE;
            state_b_q <= ST_IDLE;
            grant_a_q <= 4'd0;
            grant_b_q <= 4'd0;
            rr_ptr_q  <= 4'd0;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign valid_a_o = (state_a_q == ST_BUSY);
    assign valid_b_o = (state_b_q == ST_BUSY);
    assign grant_a_o = grant_a_q;
    assign grant_b_o = grant_b_q;
    assign rr_ptr_o  = rr_ptr_q;

endmodule
